apb_slave_mem: RTL and testbench



---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_slave_mem.sv | 110 +++++++++++
 tb/tb_apb_slave_mem.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-memory completer: FSM encoding,
// response codes and the index-width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    function automatic int log2_depth(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < depth) w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/apb_slave_mem.sv
// APB completer backed by a DEPTH-word register memory, with WAIT_CYCLES
// wait states before PREADY and PSLVERR on misaligned/out-of-range addresses.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int IDX_W = log2_depth(DEPTH);

    state_t                state;
    logic [3:0]            cnt;
    logic [IDX_W-1:0]      idx_q;
    logic                  err_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  setup;
    logic [IDX_W-1:0]      idx_in;
    logic                  err_in;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_err;
    logic                  cur_write;
    logic                  go_resp;
    logic [DATA_WIDTH-1:0] rd_data;

    assign setup  = PSELx && !PENABLE;
    assign idx_in = PADDR[2 +: IDX_W];
    // DEPTH is a power of two, so "PADDR >= DEPTH*4" is any bit set above the index
    assign err_in = (PADDR[1:0] != 2'b00) || (PADDR[ADDR_WIDTH-1:IDX_W+2] != '0);

    // With zero wait states RESP is entered straight from the setup edge,
    // before the latched copies exist, so use the live bus values there.
    assign cur_idx   = (state == ST_IDLE) ? idx_in  : idx_q;
    assign cur_err   = (state == ST_IDLE) ? err_in  : err_q;
    assign cur_write = (state == ST_IDLE) ? PWRITE  : write_q;
    assign rd_data   = (cur_write || cur_err) ? '0 : mem[cur_idx];

    assign go_resp = ((state == ST_IDLE) && setup && (WAIT_CYCLES == 0)) ||
                     ((state == ST_WAIT) && PSELx && (cnt == 4'd0));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            PREADY  <= 1'b0;
            PSLVERR <= RESP_OKAY;
            PRDATA  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        idx_q   <= idx_in;
                        err_q   <= err_in;
                        write_q <= PWRITE;
                        if (WAIT_CYCLES != 0) begin
                            state <= ST_WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSELx) begin
                        state <= ST_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (PSELx && PENABLE && write_q && !err_q) begin
                        mem[idx_q] <= PWDATA;
                    end
                    state   <= ST_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= RESP_OKAY;
                    PRDATA  <= '0;
                end
                default: state <= ST_IDLE;
            endcase

            if (go_resp) begin
                state   <= ST_RESP;
                PREADY  <= 1'b1;
                PSLVERR <= cur_err ? RESP_ERROR : RESP_OKAY;
                PRDATA  <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (1, 0 and 3 wait states) driven
// through directed and random transfers against an array-based memory model.
module tb_apb_slave_mem;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n   [N];
    logic        psel    [N];
    logic        pen     [N];
    logic        pwr     [N];
    logic [31:0] paddr   [N];
    logic [31:0] pwdata  [N];
    logic [31:0] prdata  [N];
    logic        pready  [N];
    logic        pslverr [N];

    logic [31:0] model [N][16];
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            apb_slave_mem #(
                .ADDR_WIDTH (32),
                .DATA_WIDTH (32),
                .DEPTH      (16),
                .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
            ) dut (
                .PCLK   (clk),
                .PRESETn(rst_n[g]),
                .PSELx  (psel[g]),
                .PENABLE(pen[g]),
                .PWRITE (pwr[g]),
                .PADDR  (paddr[g]),
                .PWDATA (pwdata[g]),
                .PRDATA (prdata[g]),
                .PREADY (pready[g]),
                .PSLVERR(pslverr[g])
            );
        end
    endgenerate

    function automatic int wc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic bit addr_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd64);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model(input int k);
        for (int i = 0; i < 16; i++) model[k][i] = 32'h0;
    endtask

    // One complete transfer; address/direction are scrambled after setup
    // since the completer must work from what it captured at setup.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
        int          n;
        bit          got;
        logic [31:0] rd;
        logic        se;
        bit          e;
        @(negedge clk);
        psel[k] = 1'b1; pen[k] = 1'b0; pwr[k] = wr;
        paddr[k] = addr; pwdata[k] = wdata;
        n = 0; got = 0; rd = 'x; se = 1'bx;
        while (!got && n < 24) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                pen[k] = 1'b1;
                paddr[k] = $urandom;
                pwr[k] = ~wr;
            end
            if (pready[k]) begin
                got = 1; rd = prdata[k]; se = pslverr[k];
            end
        end
        e = addr_err(addr);
        chk({tag, " ready"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'(wc(k) + 1));
        chk({tag, " pslverr"}, 32'(se), 32'(e));
        chk({tag, " prdata"}, rd, (wr || e) ? 32'h0 : model[k][word_of(addr)]);
        @(posedge clk);
        if (wr && !e) model[k][word_of(addr)] = wdata;
        #1;
        chk({tag, " ready drop"}, 32'(pready[k]), 32'd0);
    endtask

    task automatic idle(input int k, input int cyc);
        bit seen;
        seen = 0;
        @(negedge clk);
        psel[k] = 1'b0; pen[k] = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (pready[k]) seen = 1;
        end
        chk("idle ready", 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit          seen;
        int          n;
        logic [31:0] a;
        for (int k = 0; k < N; k++) begin
            rst_n[k] = 1'b0; psel[k] = 1'b0; pen[k] = 1'b0; pwr[k] = 1'b0;
            paddr[k] = 32'h0; pwdata[k] = 32'h0;
            clear_model(k);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("reset pready", 32'(pready[k]), 32'd0);
            chk("reset pslverr", 32'(pslverr[k]), 32'd0);
            chk("reset prdata", prdata[k], 32'h0);
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) rst_n[k] = 1'b1;

        // One wait state: basic write/read, unwritten word, error responses
        xfer(0, 1, 32'h8,  32'hDEAD_BEEF, "wr 8");
        xfer(0, 0, 32'h8,  32'h0, "rd 8");
        xfer(0, 0, 32'h3C, 32'h0, "rd 3C");
        xfer(0, 1, 32'h40, 32'h1234_5678, "wr 40 oor");
        xfer(0, 1, 32'h6,  32'h8765_4321, "wr 6 misalign");
        xfer(0, 0, 32'h0,  32'h0, "rd 0");
        xfer(0, 0, 32'h41, 32'h0, "rd 41 err");

        // Zero wait states, back to back
        xfer(1, 1, 32'h4, 32'h11, "b2b wr 4");
        xfer(1, 0, 32'h4, 32'h0, "b2b rd 4");

        // Three wait states: select dropped during WAIT aborts the write
        @(negedge clk);
        psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b1; paddr[2] = 32'h0; pwdata[2] = 32'hFF;
        @(negedge clk);
        pen[2] = 1'b1;
        @(negedge clk);
        psel[2] = 1'b0; pen[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pready[2]) seen = 1;
        end
        chk("abort no ready", 32'(seen), 32'd0);
        xfer(2, 0, 32'h0, 32'h0, "abort rd 0");

        // Reset pulse during WAIT wipes memory and drops the pending write
        xfer(2, 1, 32'hC, 32'h5, "pre-rst wr C");
        xfer(2, 0, 32'hC, 32'h0, "pre-rst rd C");
        @(negedge clk);
        psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b1; paddr[2] = 32'hC; pwdata[2] = 32'hAA;
        @(negedge clk);
        pen[2] = 1'b1;
        #2 rst_n[2] = 1'b0;
        #1;
        chk("rst wait pready", 32'(pready[2]), 32'd0);
        chk("rst wait pslverr", 32'(pslverr[2]), 32'd0);
        chk("rst wait prdata", prdata[2], 32'h0);
        clear_model(2);
        psel[2] = 1'b0; pen[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        xfer(2, 0, 32'hC, 32'h0, "post-rst rd C");

        // Reset while PREADY is high clears the outputs without a clock edge
        @(negedge clk);
        psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b0; paddr[0] = 32'h8;
        n = 0; seen = 0;
        while (!seen && n < 24) begin
            @(negedge clk);
            n++;
            pen[0] = 1'b1;
            if (pready[0]) seen = 1;
        end
        chk("resp rd 8 data", prdata[0], model[0][2]);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("async pready", 32'(pready[0]), 32'd0);
        chk("async prdata", prdata[0], 32'h0);
        clear_model(0);
        psel[0] = 1'b0; pen[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        xfer(0, 0, 32'h8, 32'h0, "post-async rd 8");

        // Random traffic against the model on the 1- and 0-wait instances
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 40; t++) begin
                n = $urandom_range(0, 9);
                if (n < 7)      a = 32'($urandom_range(0, 15)) * 4;
                else if (n < 9) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
                else            a = 32'h40 + 32'($urandom_range(0, 4095));
                xfer(k, ($urandom_range(0, 1) == 1), a, $urandom, "rand");
                if ($urandom_range(0, 4) == 0) idle(k, $urandom_range(1, 3));
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
